opcode_step_decoder: RTL and testbench

- Registered, parametrised successor to the processor's opcode one-hot decoder.
- Latches an opcode, drives a one-hot control vector, and sequences a one-hot timing-step ring (T0..Tn-1) so multi-cycle instructions get per-step strobes.
- Flags out-of-range opcodes and signals completion.
- Sits between the instruction register and the datapath control lines.

---
 rtl/opcode_step_decoder.sv | 98 +++++++++
 tb/tb_opcode_step_decoder.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/opcode_step_decoder.sv
// Registered opcode decoder with a one-hot timing-step ring for multi-cycle instructions.
// Latches an accepted opcode, drives a gated one-hot control vector, and flags rejects and completion.
module opcode_step_decoder #(
  parameter int SEL_W   = 4,
  parameter int N_OUT   = 12,
  parameter int N_STEPS = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [SEL_W-1:0]   in,
  input  logic               en_op,
  input  logic               en_out,
  input  logic               clr,
  output logic [N_OUT-1:0]   out,
  output logic [SEL_W-1:0]   op,
  output logic [N_STEPS-1:0] step,
  output logic               busy,
  output logic               done,
  output logic               err
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  localparam logic [SEL_W:0] N_OUT_W = (SEL_W+1)'(N_OUT);

  state_t             state_q;
  logic [N_OUT-1:0]   out_q;
  logic [SEL_W-1:0]   op_q;
  logic [N_STEPS-1:0] step_q;
  logic               busy_q;
  logic               done_q;
  logic               err_q;
  logic               in_valid;

  function automatic logic [N_OUT-1:0] onehot(input logic [SEL_W-1:0] k);
    onehot = N_OUT'(1) << k;
  endfunction

  assign in_valid = ({1'b0, in} < N_OUT_W);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      out_q   <= '0;
      op_q    <= '0;
      step_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else if (clr) begin
      // op is deliberately kept so the aborted opcode stays visible
      state_q <= IDLE;
      out_q   <= '0;
      step_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (en_op) begin
            if (in_valid) begin
              state_q <= ACTIVE;
              op_q    <= in;
              step_q  <= N_STEPS'(1);
              busy_q  <= 1'b1;
              if (en_out) out_q <= onehot(in);
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        ACTIVE: begin
          if (en_out) out_q <= onehot(op_q);
          if (step_q[N_STEPS-1]) begin
            state_q <= IDLE;
            step_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            step_q <= {step_q[N_STEPS-2:0], 1'b0};
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out  = out_q;
  assign op   = op_q;
  assign step = step_q;
  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;

endmodule

// File: tb/tb_opcode_step_decoder.sv
// Bench for opcode_step_decoder: default and small-parameter instances checked every cycle
// against a counter-based behavioural model, plus directed literal expectations.
module tb_opcode_step_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic        en_op = 1'b0;
  logic        en_out = 1'b0;
  logic [3:0]  in = '0;
  logic [2:0]  b_in;

  logic [11:0] a_out;  logic [3:0] a_op;  logic [3:0] a_step;
  logic        a_busy, a_done, a_err;
  logic [7:0]  b_out;  logic [2:0] b_op;  logic [1:0] b_step;
  logic        b_busy, b_done, b_err;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  bit chk_en = 0;

  assign b_in = in[2:0];

  opcode_step_decoder #(.SEL_W(4), .N_OUT(12), .N_STEPS(4)) dut_a (
    .clk(clk), .rst(rst), .in(in), .en_op(en_op), .en_out(en_out), .clr(clr),
    .out(a_out), .op(a_op), .step(a_step), .busy(a_busy), .done(a_done), .err(a_err));

  opcode_step_decoder #(.SEL_W(3), .N_OUT(8), .N_STEPS(2)) dut_b (
    .clk(clk), .rst(rst), .in(b_in), .en_op(en_op), .en_out(en_out), .clr(clr),
    .out(b_out), .op(b_op), .step(b_step), .busy(b_busy), .done(b_done), .err(b_err));

  always #5 clk = ~clk;

  // Behavioural model: step position is an integer index, an instruction is "active" for N_STEPS edges.
  int unsigned NO [2] = '{12, 8};
  int unsigned NS [2] = '{4, 2};
  bit          m_act  [2];
  int unsigned m_pos  [2];
  int unsigned m_op   [2];
  logic [31:0] m_out  [2];
  bit          m_done [2];
  bit          m_err  [2];

  initial begin
    for (int d = 0; d < 2; d++) begin
      m_act[d] = 0; m_pos[d] = 0; m_op[d] = 0; m_out[d] = '0; m_done[d] = 0; m_err[d] = 0;
    end
  end

  always @(posedge clk) begin
    int unsigned opc;
    cyc++;
    for (int d = 0; d < 2; d++) begin
      opc = (d == 0) ? 32'(in) : 32'(in & 4'd7);
      if (rst) begin
        m_act[d] = 0; m_pos[d] = 0; m_op[d] = 0; m_out[d] = '0; m_done[d] = 0; m_err[d] = 0;
      end else if (clr) begin
        m_act[d] = 0; m_pos[d] = 0; m_out[d] = '0; m_done[d] = 0; m_err[d] = 0;
      end else begin
        m_done[d] = 0;
        m_err[d]  = 0;
        if (m_act[d]) begin
          if (en_out) m_out[d] = 32'd1 << m_op[d];
          if (m_pos[d] == NS[d] - 1) begin
            m_act[d]  = 0;
            m_pos[d]  = 0;
            m_done[d] = 1;
          end else begin
            m_pos[d]++;
          end
        end else if (en_op) begin
          if (opc < NO[d]) begin
            m_op[d]  = opc;
            m_act[d] = 1;
            m_pos[d] = 0;
            if (en_out) m_out[d] = 32'd1 << opc;
          end else begin
            m_err[d] = 1;
          end
        end
      end
    end
  end

  task automatic cmp(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d cycle %0d: got 0x%0h expected 0x%0h", name, d, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        logic [31:0] e_step;
        e_step = m_act[d] ? (32'd1 << m_pos[d]) : 32'd0;
        if (d == 0) begin
          cmp("out",  d, 32'(a_out),  m_out[d]);
          cmp("op",   d, 32'(a_op),   m_op[d]);
          cmp("step", d, 32'(a_step), e_step);
          cmp("busy", d, 32'(a_busy), 32'(m_act[d]));
          cmp("done", d, 32'(a_done), 32'(m_done[d]));
          cmp("err",  d, 32'(a_err),  32'(m_err[d]));
          cmp("done_err_excl", d, 32'(a_done & a_err), 32'd0);
        end else begin
          cmp("out",  d, 32'(b_out),  m_out[d]);
          cmp("op",   d, 32'(b_op),   m_op[d]);
          cmp("step", d, 32'(b_step), e_step);
          cmp("busy", d, 32'(b_busy), 32'(m_act[d]));
          cmp("done", d, 32'(b_done), 32'(m_done[d]));
          cmp("err",  d, 32'(b_err),  32'(m_err[d]));
          cmp("done_err_excl", d, 32'(b_done & b_err), 32'd0);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp(name, 9, act, exp);
  endtask

  initial begin
    tick();
    chk_en = 1;
    tick();
    rst = 0;
    chk("rst_out", 32'(a_out), 32'h0);
    chk("rst_busy", 32'(a_busy), 32'h0);
    chk("rst_step", 32'(a_step), 32'h0);

    // Basic accept of opcode 5
    in = 4'd5; en_op = 1; en_out = 1;
    tick(); en_op = 0;
    chk("acc_out", 32'(a_out), 32'h020);
    chk("acc_op", 32'(a_op), 32'd5);
    chk("acc_step", 32'(a_step), 32'b0001);
    chk("acc_busy", 32'(a_busy), 32'd1);
    tick(); chk("t1", 32'(a_step), 32'b0010);
    tick(); chk("t2", 32'(a_step), 32'b0100);
    tick(); chk("t3", 32'(a_step), 32'b1000);
    tick();
    chk("done_pulse", 32'(a_done), 32'd1);
    chk("done_busy", 32'(a_busy), 32'd0);
    chk("done_out_hold", 32'(a_out), 32'h020);
    tick(); chk("done_one_cycle", 32'(a_done), 32'd0);

    // Out-of-range rejects
    in = 4'd12; en_op = 1;
    tick();
    chk("err12", 32'(a_err), 32'd1);
    chk("err12_busy", 32'(a_busy), 32'd0);
    chk("err12_op", 32'(a_op), 32'd5);
    in = 4'd15;
    tick(); chk("err15", 32'(a_err), 32'd1);
    en_op = 0;
    tick(); chk("err_clear", 32'(a_err), 32'd0);

    // Output gating
    en_out = 0; in = 4'd11; en_op = 1;
    tick(); en_op = 0;
    chk("gate_out", 32'(a_out), 32'h020);
    chk("gate_op", 32'(a_op), 32'd11);
    tick();
    tick(); chk("gate_t2", 32'(a_step), 32'b0100);
    en_out = 1;
    tick(); chk("gate_release", 32'(a_out), 32'h800);
    tick(); chk("gate_done", 32'(a_done), 32'd1);

    // Back-to-back from the done cycle, then en_op ignored while busy
    in = 4'd3; en_op = 1;
    tick();
    chk("b2b_busy", 32'(a_busy), 32'd1);
    chk("b2b_step", 32'(a_step), 32'b0001);
    chk("b2b_out", 32'(a_out), 32'h008);
    tick();
    in = 4'd15;
    tick(); chk("busy_ign_err", 32'(a_err), 32'd0);
    chk("busy_ign_op", 32'(a_op), 32'd3);
    en_op = 0;
    tick(); tick();

    // Abort with clr at T2
    in = 4'd7; en_op = 1;
    tick(); en_op = 0;
    tick(); tick();
    clr = 1;
    tick(); clr = 0;
    chk("clr_busy", 32'(a_busy), 32'd0);
    chk("clr_out", 32'(a_out), 32'h0);
    chk("clr_op", 32'(a_op), 32'd7);
    tick(); chk("clr_no_done", 32'(a_done), 32'd0);
    in = 4'd0; en_op = 1;
    tick(); en_op = 0;
    chk("after_clr_out", 32'(a_out), 32'h001);

    // Reset mid-instruction at T1
    tick();
    rst = 1;
    tick(); rst = 0;
    chk("rstmid_out", 32'(a_out), 32'h0);
    chk("rstmid_busy", 32'(a_busy), 32'd0);
    tick(); chk("rstmid_no_done", 32'(a_done), 32'd0);

    // Small instance: two-step instructions
    in = 4'd7; en_op = 1;
    tick(); en_op = 0;
    chk("b_out", 32'(b_out), 32'h80);
    chk("b_step0", 32'(b_step), 32'b01);
    tick(); chk("b_step1", 32'(b_step), 32'b10);
    chk("b_busy", 32'(b_busy), 32'd1);
    tick(); chk("b_done", 32'(b_done), 32'd1);
    chk("b_idle", 32'(b_busy), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst    = ($urandom_range(0, 149) == 0);
      clr    = ($urandom_range(0, 59) == 0);
      en_op  = ($urandom_range(0, 2) != 0);
      en_out = ($urandom_range(0, 3) != 0);
      in     = 4'($urandom_range(0, 15));
      tick();
    end
    rst = 0; clr = 0; en_op = 0;
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
